// File: rtl/td4_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : td4_pkg
//  Description : Shared definitions for the TD4 instruction fetch block:
//                opcode constants, program ROM geometry and the fetch FSM
//                state encoding.
//  Revision    : 1.0 - initial release
// ============================================================================
package td4_pkg;

  // Opcode field values ([7:4] of a program byte)
  localparam logic [3:0] OP_ADD_A = 4'b0000;
  localparam logic [3:0] OP_MOV_A = 4'b0011;
  localparam logic [3:0] OP_ADD_B = 4'b0101;
  localparam logic [3:0] OP_MOV_B = 4'b0111;
  localparam logic [3:0] OP_JNC   = 4'b1110;
  localparam logic [3:0] OP_JMP   = 4'b1111;

  // Program ROM geometry
  localparam int ROM_DEPTH = 16;
  localparam int ADDR_W    = $clog2(ROM_DEPTH);
  localparam int DATA_W    = 8;

  // Fetch FSM state encoding; 2'b11 is illegal and recovers to ST_LOAD
  typedef enum logic [1:0] {
    ST_LOAD = 2'b00,
    ST_RUN  = 2'b01,
    ST_HALT = 2'b10
  } fetch_state_e;

  // Sequential successor of a ROM address, wrapping modulo ROM_DEPTH
  function automatic logic [ADDR_W-1:0] pc_inc(input logic [ADDR_W-1:0] pc);
    return pc + ADDR_W'(1);
  endfunction

endpackage : td4_pkg
`default_nettype wire

// File: rtl/td4_prog_rom.sv
`default_nettype none
// ============================================================================
//  Module      : td4_prog_rom
//  Description : 16 x 8 program store. One synchronous write port, one
//                asynchronous read port, whole array cleared synchronously
//                while rst is high.
//  Ports       : clk, rst     - clock / synchronous active-high clear
//                we_i         - write enable
//                waddr_i      - write address
//                wdata_i      - write data
//                raddr_i      - read address
//                rdata_o      - read data (combinational from raddr_i)
//  Revision    : 1.0 - initial release
// ============================================================================
module td4_prog_rom
  import td4_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic [ADDR_W-1:0] raddr_i,
  output logic [DATA_W-1:0] rdata_o
);

  logic [DATA_W-1:0] mem_q [ROM_DEPTH];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < ROM_DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule : td4_prog_rom
`default_nettype wire

// File: rtl/td4_fetch.sv
`default_nettype none
// ============================================================================
//  Module      : td4_fetch
//  Description : TD4 instruction fetch. Loads a 16-byte program through a
//                valid/ready byte interface, then walks the program counter,
//                resolving JMP / JNC and parking in HALT on a JMP to itself.
//  Ports       : clk, rst            - clock / synchronous active-high reset
//                step                - single-step advance (TD4_FETCH_STEP_EN)
//                prog_valid/ready    - program byte handshake
//                prog_data           - program byte ([7:4] op, [3:0] imm)
//                run                 - start execution from pc=0 (LOAD/HALT)
//                carry_i             - carry flag, consulted by JNC
//                opcode, immediate   - fields of rom[pc]
//                pc                  - current instruction address
//                instr_valid         - instruction is executed this cycle
//                halted              - block is in HALT
//  Config      : TD4_FETCH_STEP_EN - when defined, adds the step input and
//                gates RUN-state pc advance on it.
//  Revision    : 1.0 - initial release
// ============================================================================
module td4_fetch
  import td4_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
`ifdef TD4_FETCH_STEP_EN
  input  logic              step,
`endif
  input  logic              prog_valid,
  output logic              prog_ready,
  input  logic [DATA_W-1:0] prog_data,
  input  logic              run,
  input  logic              carry_i,
  output logic [3:0]        opcode,
  output logic [3:0]        immediate,
  output logic [ADDR_W-1:0] pc,
  output logic              instr_valid,
  output logic              halted
);

  fetch_state_e      state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [ADDR_W-1:0] load_ptr_q, load_ptr_d;

  logic              w_rom_we;
  logic [DATA_W-1:0] w_rom_rdata;
  logic              w_advance;
  logic              w_self_jmp;
  logic [ADDR_W-1:0] w_next_pc;

  td4_prog_rom u_rom (
    .clk     (clk),
    .rst     (rst),
    .we_i    (w_rom_we),
    .waddr_i (load_ptr_q),
    .wdata_i (prog_data),
    .raddr_i (pc_q),
    .rdata_o (w_rom_rdata)
  );

  assign opcode    = w_rom_rdata[7:4];
  assign immediate = w_rom_rdata[3:0];
  assign pc        = pc_q;

`ifdef TD4_FETCH_STEP_EN
  assign w_advance = step;
`else
  assign w_advance = 1'b1;
`endif

  // A JMP onto its own address is the program's stop idiom.
  assign w_self_jmp = (opcode == OP_JMP) && (immediate == pc_q);

  always_comb begin
    w_next_pc = pc_inc(pc_q);
    if (opcode == OP_JMP) begin
      w_next_pc = immediate;
    end else if ((opcode == OP_JNC) && !carry_i) begin
      w_next_pc = immediate;
    end
  end

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    load_ptr_d  = load_ptr_q;
    w_rom_we    = 1'b0;
    prog_ready  = 1'b0;
    instr_valid = 1'b0;
    halted      = 1'b0;
    case (state_q)
      ST_LOAD: begin
        prog_ready = 1'b1;
        if (prog_valid) begin
          w_rom_we   = 1'b1;
          load_ptr_d = pc_inc(load_ptr_q);
          if (load_ptr_q == ADDR_W'(ROM_DEPTH - 1)) begin
            state_d = ST_RUN;
            pc_d    = '0;
          end
        end
        // The byte accepted in this cycle is still written above.
        if (run) begin
          state_d = ST_RUN;
          pc_d    = '0;
        end
      end
      ST_RUN: begin
        instr_valid = w_advance;
        if (w_advance) begin
          if (w_self_jmp) begin
            state_d = ST_HALT;
          end else begin
            pc_d = w_next_pc;
          end
        end
      end
      ST_HALT: begin
        halted = 1'b1;
        if (run) begin
          state_d = ST_RUN;
          pc_d    = '0;
        end
      end
      default: begin
        state_d    = ST_LOAD;
        pc_d       = '0;
        load_ptr_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_LOAD;
      pc_q       <= '0;
      load_ptr_q <= '0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      load_ptr_q <= load_ptr_d;
    end
  end

endmodule : td4_fetch
`default_nettype wire

// File: tb/tb_td4_fetch.sv
`default_nettype none
// ============================================================================
//  Module      : tb_td4_fetch
//  Description : Directed self-checking bench for td4_fetch.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_td4_fetch;

  logic       clk;
  logic       rst;
`ifdef TD4_FETCH_STEP_EN
  logic       step;
`endif
  logic       prog_valid;
  logic       prog_ready;
  logic [7:0] prog_data;
  logic       run;
  logic       carry_i;
  logic [3:0] opcode;
  logic [3:0] immediate;
  logic [3:0] pc;
  logic       instr_valid;
  logic       halted;

  int checks;
  int failures;

  td4_fetch dut (
    .clk         (clk),
    .rst         (rst),
`ifdef TD4_FETCH_STEP_EN
    .step        (step),
`endif
    .prog_valid  (prog_valid),
    .prog_ready  (prog_ready),
    .prog_data   (prog_data),
    .run         (run),
    .carry_i     (carry_i),
    .opcode      (opcode),
    .immediate   (immediate),
    .pc          (pc),
    .instr_valid (instr_valid),
    .halted      (halted)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Inputs change 1 time unit after the rising edge; outputs are sampled there too.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic reset_dut();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic load_byte(input logic [7:0] b);
    prog_valid = 1'b1;
    prog_data  = b;
    tick();
    prog_valid = 1'b0;
  endtask

  // Last program byte accepted together with run=1
  task automatic load_byte_and_run(input logic [7:0] b);
    prog_valid = 1'b1;
    prog_data  = b;
    run        = 1'b1;
    tick();
    prog_valid = 1'b0;
    run        = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; run = 1'b1; prog_valid = 1'b1; prog_data = 8'hAB;
    tick();
    rst = 1'b0; run = 1'b0; prog_valid = 1'b0;
    checks++; if (pc !== 4'h0) begin failures++; $display("FAIL reset_pc got=%0h exp=0", pc); end
    checks++; if (halted !== 1'b0) begin failures++; $display("FAIL reset_halted got=%0b exp=0", halted); end
    checks++; if (instr_valid !== 1'b0) begin failures++; $display("FAIL reset_instr_valid got=%0b exp=0", instr_valid); end
    checks++; if (prog_ready !== 1'b1) begin failures++; $display("FAIL reset_prog_ready got=%0b exp=1", prog_ready); end
    checks++; if ({opcode, immediate} !== 8'h00) begin failures++; $display("FAIL reset_rom0 got=%0h exp=00", {opcode, immediate}); end
  endtask

  task automatic test_load();
    reset_dut();
    load_byte(8'h31);
    load_byte(8'h72);
    prog_valid = 1'b0;
    tick();
    checks++; if (prog_ready !== 1'b1 || instr_valid !== 1'b0) begin failures++;
      $display("FAIL load_gap got ready=%0b iv=%0b exp ready=1 iv=0", prog_ready, instr_valid); end
    for (int i = 2; i < 15; i++) load_byte(8'h00);
    checks++; if (instr_valid !== 1'b0 || prog_ready !== 1'b1) begin failures++;
      $display("FAIL load_15 got iv=%0b ready=%0b exp iv=0 ready=1", instr_valid, prog_ready); end
    load_byte(8'h00);
    checks++; if (instr_valid !== 1'b1 || prog_ready !== 1'b0) begin failures++;
      $display("FAIL load_16_run got iv=%0b ready=%0b exp iv=1 ready=0", instr_valid, prog_ready); end
    checks++; if (pc !== 4'h0 || opcode !== 4'h3 || immediate !== 4'h1) begin failures++;
      $display("FAIL load_first_instr got pc=%0h op=%0h imm=%0h exp pc=0 op=3 imm=1", pc, opcode, immediate); end
    tick();
    checks++; if (pc !== 4'h1 || opcode !== 4'h7 || immediate !== 4'h2) begin failures++;
      $display("FAIL load_second_instr got pc=%0h op=%0h imm=%0h exp pc=1 op=7 imm=2", pc, opcode, immediate); end
  endtask

  task automatic test_sequence();
    logic [3:0] exp_pc [5];
    logic [3:0] exp_op [5];
    exp_pc = '{4'h0, 4'h1, 4'h2, 4'h0, 4'h1};
    exp_op = '{4'h0, 4'h0, 4'hF, 4'h0, 4'h0};
    reset_dut();
    load_byte(8'h01);
    load_byte(8'h01);
    load_byte_and_run(8'hF0);
    for (int i = 0; i < 5; i++) begin
      checks++; if (pc !== exp_pc[i] || instr_valid !== 1'b1 || opcode !== exp_op[i]) begin failures++;
        $display("FAIL seq_step%0d got pc=%0h iv=%0b op=%0h exp pc=%0h iv=1 op=%0h",
                 i, pc, instr_valid, opcode, exp_pc[i], exp_op[i]); end
      tick();
    end
  endtask

  task automatic test_jnc();
    reset_dut();
    load_byte(8'h00);
    load_byte(8'h00);
    load_byte(8'h00);
    load_byte_and_run(8'hE7);
    carry_i = 1'b0;
    repeat (3) tick();
    checks++; if (pc !== 4'h3 || opcode !== 4'hE || immediate !== 4'h7) begin failures++;
      $display("FAIL jnc_at3 got pc=%0h op=%0h imm=%0h exp pc=3 op=e imm=7", pc, opcode, immediate); end
    tick();
    checks++; if (pc !== 4'h7) begin failures++; $display("FAIL jnc_taken got pc=%0h exp=7", pc); end
    carry_i = 1'b1;
    // 7..15, wrap to 0, then 1..3
    repeat (12) tick();
    checks++; if (pc !== 4'h3) begin failures++; $display("FAIL jnc_wrap_back got pc=%0h exp=3", pc); end
    tick();
    checks++; if (pc !== 4'h4) begin failures++; $display("FAIL jnc_not_taken got pc=%0h exp=4", pc); end
    carry_i = 1'b0;
  endtask

  task automatic test_halt();
    reset_dut();
    for (int i = 0; i < 5; i++) load_byte(8'h00);
    load_byte_and_run(8'hF5);
    repeat (5) tick();
    checks++; if (pc !== 4'h5 || instr_valid !== 1'b1 || halted !== 1'b0 || opcode !== 4'hF) begin failures++;
      $display("FAIL halt_pre got pc=%0h iv=%0b h=%0b op=%0h exp pc=5 iv=1 h=0 op=f", pc, instr_valid, halted, opcode); end
    tick();
    checks++; if (halted !== 1'b1 || instr_valid !== 1'b0 || pc !== 4'h5 || prog_ready !== 1'b0) begin failures++;
      $display("FAIL halt_enter got h=%0b iv=%0b pc=%0h ready=%0b exp h=1 iv=0 pc=5 ready=0", halted, instr_valid, pc, prog_ready); end
    prog_valid = 1'b1; prog_data = 8'h9A;
    tick();
    prog_valid = 1'b0;
    checks++; if (halted !== 1'b1 || pc !== 4'h5 || prog_ready !== 1'b0) begin failures++;
      $display("FAIL halt_hold got h=%0b pc=%0h ready=%0b exp h=1 pc=5 ready=0", halted, pc, prog_ready); end
    run = 1'b1;
    tick();
    run = 1'b0;
    checks++; if (pc !== 4'h0 || instr_valid !== 1'b1 || halted !== 1'b0) begin failures++;
      $display("FAIL halt_restart got pc=%0h iv=%0b h=%0b exp pc=0 iv=1 h=0", pc, instr_valid, halted); end
    repeat (5) tick();
    checks++; if (pc !== 4'h5 || opcode !== 4'hF || immediate !== 4'h5) begin failures++;
      $display("FAIL halt_rom_kept got pc=%0h op=%0h imm=%0h exp pc=5 op=f imm=5", pc, opcode, immediate); end
    tick();
    checks++; if (halted !== 1'b1) begin failures++; $display("FAIL halt_again got h=%0b exp=1", halted); end
  endtask

  task automatic test_wrap_and_reset();
    logic [7:0] exp_b;
    reset_dut();
    for (int i = 0; i < 15; i++) load_byte(8'h00);
    load_byte(8'h01);
    repeat (15) tick();
    checks++; if (pc !== 4'hF || opcode !== 4'h0 || immediate !== 4'h1) begin failures++;
      $display("FAIL wrap_at15 got pc=%0h op=%0h imm=%0h exp pc=f op=0 imm=1", pc, opcode, immediate); end
    tick();
    checks++; if (pc !== 4'h0 || instr_valid !== 1'b1) begin failures++;
      $display("FAIL wrap_to0 got pc=%0h iv=%0b exp pc=0 iv=1", pc, instr_valid); end
    // Reset in the middle of a load
    reset_dut();
    for (int i = 0; i < 5; i++) load_byte(8'h77);
    rst = 1'b1; prog_valid = 1'b1; prog_data = 8'h66;
    tick();
    rst = 1'b0; prog_valid = 1'b0;
    checks++; if (prog_ready !== 1'b1 || instr_valid !== 1'b0 || pc !== 4'h0) begin failures++;
      $display("FAIL midload_reset got ready=%0b iv=%0b pc=%0h exp ready=1 iv=0 pc=0", prog_ready, instr_valid, pc); end
    load_byte_and_run(8'h35);
    for (int i = 0; i < 16; i++) begin
      exp_b = (i == 0) ? 8'h35 : 8'h00;
      checks++; if (pc !== 4'(i) || {opcode, immediate} !== exp_b) begin failures++;
        $display("FAIL cleared_rom%0d got pc=%0h byte=%0h exp pc=%0h byte=%0h", i, pc, {opcode, immediate}, i, exp_b); end
      tick();
    end
  endtask

`ifdef TD4_FETCH_STEP_EN
  task automatic test_step();
    reset_dut();
    load_byte_and_run(8'h00);
    step = 1'b0;
    for (int i = 0; i < 4; i++) begin
      checks++; if (pc !== 4'h0 || instr_valid !== 1'b0) begin failures++;
        $display("FAIL step_frozen%0d got pc=%0h iv=%0b exp pc=0 iv=0", i, pc, instr_valid); end
      tick();
    end
    step = 1'b1;
    checks++; if (instr_valid !== 1'b1) begin failures++; $display("FAIL step_iv got=%0b exp=1", instr_valid); end
    tick();
    step = 1'b0;
    checks++; if (pc !== 4'h1) begin failures++; $display("FAIL step_advance got pc=%0h exp=1", pc); end
    tick();
    checks++; if (pc !== 4'h1) begin failures++; $display("FAIL step_single got pc=%0h exp=1", pc); end
    step = 1'b1;
  endtask
`endif

  initial begin
    checks = 0; failures = 0;
    rst = 1'b1; prog_valid = 1'b0; prog_data = 8'h00; run = 1'b0; carry_i = 1'b0;
`ifdef TD4_FETCH_STEP_EN
    step = 1'b1;
`endif
    test_reset();
    test_load();
    test_sequence();
    test_jnc();
    test_halt();
    test_wrap_and_reset();
`ifdef TD4_FETCH_STEP_EN
    test_step();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_td4_fetch
`default_nettype wire
